// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 868;
    localparam int UART_CNT_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    function automatic logic even_parity_ok(input logic [UART_DATA_W-1:0] d, input logic p);
        return ~(^{d, p});
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous circular-buffer FIFO holding received bytes; pop is serviced before push,
// so a full queue that is popped in the same cycle still accepts the incoming word.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             accepted
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign accepted = do_push;
    assign dout     = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a byte queue.
// Define UART_RX_PARITY_EN for 8E1 framing with a live io_parityErr; default is 8N1.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_rx,
    output logic [UART_DATA_W-1:0] io_data,
    output logic                   io_valid,
    input  logic                   io_ready,
    output logic                   io_frameErr,
    output logic                   io_parityErr,
    output logic                   io_overrun
);

    localparam logic [UART_CNT_W-1:0] CNT_FULL = UART_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [UART_CNT_W-1:0] CNT_HALF = UART_CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic                   rx_p0;
    logic                   rx_p1;
    rx_state_t              state;
    logic [UART_CNT_W-1:0]  cnt;
    logic [2:0]             idx;
    logic                   err_flag;
    logic [UART_DATA_W-1:0] shreg;
    logic                   frame_err_r;
    logic                   overrun_r;
    logic                   cnt_zero;
    logic                   push;
    logic                   pop;
    logic                   accepted;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign cnt_zero = (cnt == '0);
    // Push is decoded from the stop-bit sample cycle so io_valid rises on the very next cycle.
    assign push     = (state == ST_STOP) && cnt_zero && rx_p1 && !err_flag;
    assign pop      = io_valid && io_ready;

`ifdef UART_RX_PARITY_EN
    logic parity_err_r;
    assign io_parityErr = parity_err_r;
`else
    assign io_parityErr = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_p0       <= 1'b1;
            rx_p1       <= 1'b1;
            state       <= ST_IDLE;
            cnt         <= '0;
            idx         <= '0;
            err_flag    <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            rx_p0       <= io_rx;
            rx_p1       <= rx_p0;
            frame_err_r <= 1'b0;
            overrun_r   <= push && !accepted;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (!rx_p1) begin
                        state <= ST_START;
                        cnt   <= CNT_HALF;
                    end
                end
                ST_START: begin
                    if (cnt_zero) begin
                        if (!rx_p1) begin
                            state    <= ST_DATA;
                            cnt      <= CNT_FULL;
                            idx      <= '0;
                            err_flag <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - UART_CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_zero) begin
                        cnt <= CNT_FULL;
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt - UART_CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_zero) begin
                        cnt      <= CNT_FULL;
                        err_flag <= !even_parity_ok(shreg, rx_p1);
                        state    <= ST_STOP;
                    end else begin
                        cnt <= cnt - UART_CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_zero) begin
                        if (rx_p1) begin
`ifdef UART_RX_PARITY_EN
                            parity_err_r <= err_flag;
`endif
                            state <= ST_IDLE;
                        end else begin
                            // A low stop bit masks any parity result for this frame.
                            frame_err_r <= 1'b1;
                            state       <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt - UART_CNT_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_p1) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if ((state == ST_DATA) && cnt_zero) shreg <= {rx_p1, shreg[UART_DATA_W-1:1]};
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .din      (shreg),
        .pop      (pop),
        .dout     (io_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .accepted (accepted)
    );

    assign io_valid    = !fifo_empty;
    assign io_frameErr = frame_err_r;
    assign io_overrun  = overrun_r;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200); legal range 8..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, received-byte queue depth; power of two, at least 2.
REQ-003 clock  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 io_rx  input  1  asynchronous serial line, idle high, 8N1 framing (8E1 with UART_RX_PARITY_EN).
REQ-006 io_data  output  8  byte at head of queue; valid only while io_valid=1.
REQ-007 io_valid  output  1  queue non-empty.
REQ-008 io_ready  input  1  consumer accepts io_data when io_valid and io_ready are both 1 in the same cycle.
REQ-009 io_frameErr  output  1  one-cycle pulse: stop bit sampled 0.
REQ-010 io_parityErr  output  1  one-cycle pulse: parity mismatch; constant 0 without UART_RX_PARITY_EN.
REQ-011 io_overrun  output  1  one-cycle pulse: good byte dropped because the queue is full.

Function
REQ-012 io_rx passes through a 2-flop synchronizer, both flops reset to 1; all decoding uses the synchronized value only.
REQ-013 States: IDLE, START, DATA, PARITY (parity builds only), STOP, WAIT_HIGH.
REQ-014 IDLE -> START when synchronized line = 0; baud counter loads CLKS_PER_BIT/2 - 1.
REQ-015 START, counter = 0: line 0 -> DATA, counter reloads CLKS_PER_BIT-1; line 1 -> IDLE (glitch); no outputs change.
REQ-016 DATA: sample at each counter expiry, shift in LSB first, 3-bit index counts 0..7; after bit 7 -> PARITY or STOP.
REQ-017 PARITY: sample at expiry; even parity over 8 data bits + parity bit; mismatch sets an internal error flag; -> STOP.
REQ-018 STOP, counter = 0, line 1: no error flag -> push byte; error flag -> io_parityErr pulse, no push; either case -> IDLE.
REQ-019 STOP, counter = 0, line 0: io_frameErr pulse, no push, -> WAIT_HIGH; parity error is not reported for that frame.
REQ-020 WAIT_HIGH -> IDLE on first synchronized 1 (break/line-low recovery).
REQ-021 Push sets io_valid the cycle after the stop-bit sample cycle; total latency from io_rx start edge is about 9.5 bit times + 3 cycles.
REQ-022 Queue: circular buffer, pointers one bit wider than log2(FIFO_DEPTH); wrap-around at FIFO_DEPTH is transparent.
REQ-023 Full queue plus push: byte discarded, io_overrun pulses, stored contents unchanged.
REQ-024 Push and pop in the same cycle, queue full: pop happens first, push accepted, no overrun.
REQ-025 Push and pop in the same cycle, queue empty: byte enters queue; io_valid rises next cycle (no bypass).
REQ-026 io_data and io_valid hold stable while io_valid=1 and io_ready=0.

Reset
REQ-027 Reset: state IDLE, counters 0, queue empty, io_valid=0, io_data=0, all error pulses 0, synchronizer flops 1.
REQ-028 Reset mid-frame aborts the frame silently; the next start edge after reset release is decoded normally.

Configuration
REQ-029 UART_RX_PARITY_EN defined: 8E1 framing, PARITY state present, io_parityErr live.
REQ-030 UART_RX_PARITY_EN undefined: 8N1 framing, DATA -> STOP directly, io_parityErr tied 0, port list unchanged.

Structure
REQ-031 Package uart_pkg holds the state enum, UART_DATA_W=8, and the default CLKS_PER_BIT constant.
REQ-032 Sub-module uart_rx_fifo (synchronous FIFO with push/pop/full/empty, parameterized depth and width) holds the queue.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-033 Serialize 0xA5 with io_ready=1 -> exactly one io_valid cycle, io_data=0xA5, no error pulses.
REQ-034 Drive io_rx low for 3 cycles in IDLE -> no io_valid, no error pulses; following 0x3C decoded correctly.
REQ-035 Send 0x55 with stop bit 0, hold line low 40 cycles -> one io_frameErr, no io_valid; following 0x81 decoded correctly.
REQ-036 io_ready=0, send 0x01..0x05 -> 0x05 raises io_overrun; then io_ready=1 drains 0x01..0x04 in order.
REQ-037 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> one io_parityErr, no io_valid; with correct parity 1 -> 0x07 delivered.
REQ-038 Assert reset in the middle of bit 4 of a frame -> all outputs at reset values; next frame 0xF0 decoded correctly.
